// File: rtl/bus_cycle_master.sv
// bus_cycle_master: 68000-style asynchronous bus cycle master with DTACK/BERR handshake and WAIT timeout.
module bus_cycle_master #(
  parameter int TIMEOUT = 64
) (
  input  logic        i_CLK,
  input  logic        i_RESET,
  input  logic        i_REQ,
  input  logic [23:0] i_REQ_ADDR,
  input  logic        i_REQ_RW,
  input  logic        i_REQ_SIZE,
  input  logic [15:0] i_REQ_WDATA,
  output logic        o_BUSY,
  output logic        o_DONE,
  output logic        o_ERR,
  output logic [15:0] o_RDATA,
  output logic [22:0] o_A,
  output logic        o_AS_n,
  output logic        o_UDS_n,
  output logic        o_LDS_n,
  output logic        o_RW,
  output logic [15:0] o_D_OUT,
  output logic        o_D_OE,
  input  logic [15:0] i_D_IN,
  input  logic        i_DTACK_n,
  input  logic        i_BERR_n
);
  typedef enum logic [2:0] {IDLE, ADDR, ASSERT, WAIT, DATA, RELEASE} state_t;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        a0_q, size_q, err_d, accept, rw_d, ds_d, misaligned;
  assign accept     = state_q == IDLE && i_REQ && i_DTACK_n;
  assign misaligned = i_REQ_SIZE && i_REQ_ADDR[0];
  assign rw_d       = accept ? i_REQ_RW : o_RW;
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    cnt_d   = state_q == WAIT ? cnt_q + 8'd1 : 8'd0;
    case (state_q)
      IDLE: if (accept) begin
        state_d = misaligned ? RELEASE : ADDR;
        err_d   = misaligned;
      end
      ADDR:   state_d = ASSERT;
      ASSERT: state_d = WAIT;
      WAIT: if (!i_BERR_n) begin
        state_d = RELEASE;
        err_d   = 1'b1;
      end else if (!i_DTACK_n) begin
        state_d = DATA;
      end else if (cnt_q == 8'(TIMEOUT - 1)) begin
        state_d = RELEASE;
        err_d   = 1'b1;
      end
      DATA:    state_d = RELEASE;
      default: state_d = IDLE;
    endcase
  end
  // Reads drop data strobes together with AS; writes wait one cycle so data is stable first.
  assign ds_d = state_d inside {WAIT, DATA} || (state_d == ASSERT && o_RW);
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      a0_q    <= 1'b0;
      size_q  <= 1'b0;
      o_A     <= '0;
      o_RW    <= 1'b1;
      o_D_OUT <= '0;
      o_D_OE  <= 1'b0;
      o_AS_n  <= 1'b1;
      o_UDS_n <= 1'b1;
      o_LDS_n <= 1'b1;
      o_BUSY  <= 1'b0;
      o_DONE  <= 1'b0;
      o_ERR   <= 1'b0;
      o_RDATA <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        a0_q    <= i_REQ_ADDR[0];
        size_q  <= i_REQ_SIZE;
        o_A     <= i_REQ_ADDR[23:1];
        o_RW    <= i_REQ_RW;
        o_D_OUT <= i_REQ_SIZE ? i_REQ_WDATA : {2{i_REQ_WDATA[7:0]}};
      end
      o_D_OE  <= !rw_d && state_d inside {ADDR, ASSERT, WAIT, DATA};
      o_AS_n  <= !(state_d inside {ASSERT, WAIT, DATA});
      o_UDS_n <= !(ds_d && (size_q || !a0_q));
      o_LDS_n <= !(ds_d && (size_q || a0_q));
      o_BUSY  <= state_d != IDLE;
      o_DONE  <= state_d == RELEASE;
      o_ERR   <= err_d;
      if (state_q == DATA && o_RW)
        o_RDATA <= size_q ? i_D_IN : {8'h00, a0_q ? i_D_IN[7:0] : i_D_IN[15:8]};
    end
  end
endmodule

// File: tb/tb_bus_cycle_master.sv
// tb_bus_cycle_master: directed table plus randomized transactions checked cycle-by-cycle against a phase-list model.
module tb_bus_cycle_master;
  localparam int T = 64;
  logic clk = 1'b0, rst = 1'b1, req = 1'b0, rw = 1'b0, size = 1'b0, dtack_n = 1'b1, berr_n = 1'b1;
  logic [23:0] addr = '0;
  logic [15:0] wdata = '0, din = '0;
  logic busy, done, err, as_n, uds_n, lds_n, o_rw, doe;
  logic [15:0] rdata, dout;
  logic [22:0] a;
  int n_cmp = 0, n_bad = 0;
  logic [15:0] m_rdata = '0;
  string pname[5] = '{"addr", "assert", "wait", "data", "release"};

  bus_cycle_master dut (
    .i_CLK(clk), .i_RESET(rst), .i_REQ(req), .i_REQ_ADDR(addr), .i_REQ_RW(rw),
    .i_REQ_SIZE(size), .i_REQ_WDATA(wdata), .o_BUSY(busy), .o_DONE(done), .o_ERR(err),
    .o_RDATA(rdata), .o_A(a), .o_AS_n(as_n), .o_UDS_n(uds_n), .o_LDS_n(lds_n),
    .o_RW(o_rw), .o_D_OUT(dout), .o_D_OE(doe), .i_D_IN(din), .i_DTACK_n(dtack_n),
    .i_BERR_n(berr_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // d: WAIT cycles before DTACK falls (-1 = never); b: WAIT cycle index with BERR low (-1 = none)
  task automatic run_txn(input logic [23:0] ad, input logic r, input logic s, input logic [15:0] wd,
                         input logic [15:0] di, input int d, input int b,
                         output int done_at, output logic e_o, output logic [15:0] rd_o);
    int ph[$];
    int term, kind, wj;
    logic e, usel, lsel;
    logic [15:0] exp_rd;
    logic [22:0] ev, av;
    usel = s | ~ad[0];
    lsel = s | ad[0];
    if (s && ad[0]) begin
      ph.push_back(4);
      e = 1'b1;
    end else begin
      term = T - 1; kind = 2;
      if (d >= 0 && d <= term) begin term = d; kind = 1; end
      if (b >= 0 && b <= term) begin term = b; kind = 0; end
      e = kind != 1;
      ph.push_back(0); ph.push_back(1);
      for (int i = 0; i <= term; i++) ph.push_back(2);
      if (kind == 1) ph.push_back(3);
      ph.push_back(4);
    end
    exp_rd = (r && !e) ? (s ? di : {8'h00, ad[0] ? di[7:0] : di[15:8]}) : m_rdata;
    @(negedge clk);
    req = 1'b1; addr = ad; rw = r; size = s; wdata = wd; din = di; dtack_n = 1'b1; berr_n = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; done_at = 0; e_o = 1'b0; rd_o = '0; wj = 0;
    for (int k = 0; k < ph.size(); k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      dtack_n = !((ph[k] == 2 && d >= 0 && wj >= d) || ph[k] == 3);
      berr_n  = !(ph[k] == 2 && wj == b);
      @(negedge clk);
      av = {as_n, uds_n, lds_n, doe, busy, done, err, rdata};
      case (ph[k])
        0: ev = {3'b111, !r, 3'b100, m_rdata};
        1: ev = {1'b0, r ? !usel : 1'b1, r ? !lsel : 1'b1, !r, 3'b100, m_rdata};
        2, 3: ev = {1'b0, !usel, !lsel, !r, 3'b100, m_rdata};
        default: ev = {4'b1110, 2'b11, e, exp_rd};
      endcase
      chk($sformatf("%s_cyc%0d_addr%h", pname[ph[k]], k + 1, ad), 32'(av), 32'(ev));
      if (ph[k] == 0) begin
        chk("a_bus", 32'(a), 32'(ad[23:1]));
        chk("rw_line", 32'(o_rw), 32'(r));
        if (!r) chk("d_out", 32'(dout), 32'(s ? wd : {wd[7:0], wd[7:0]}));
      end
      if (done) begin done_at = k + 1; e_o = err; rd_o = rdata; end
      if (ph[k] == 2) wj++;
    end
    @(posedge clk); #1;
    dtack_n = 1'b1; berr_n = 1'b1;
    @(negedge clk);
    chk("idle_after", 32'({busy, done, err, as_n}), 32'(4'b0001));
    m_rdata = exp_rd;
  endtask

  typedef struct {
    logic [23:0] ad; logic r; logic s; logic [15:0] wd; logic [15:0] di;
    int d; int b; int ex_cyc; logic ex_err; logic [15:0] ex_rd;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int dc, d, b;
    logic e;
    logic [15:0] rd;
    tbl[0] = '{24'h000100, 1'b1, 1'b1, 16'h0000, 16'hBEEF, 0, -1, 5, 1'b0, 16'hBEEF};
    tbl[1] = '{24'hF00001, 1'b0, 1'b0, 16'h005A, 16'h0000, 3, -1, 8, 1'b0, 16'hBEEF};
    tbl[2] = '{24'hE00000, 1'b1, 1'b0, 16'h0000, 16'h12AB, 0, -1, 5, 1'b0, 16'h0012};
    tbl[3] = '{24'h100000, 1'b1, 1'b1, 16'h0000, 16'h7777, -1, -1, 67, 1'b1, 16'h0012};
    tbl[4] = '{24'h000003, 1'b1, 1'b1, 16'h0000, 16'h9999, 0, -1, 1, 1'b1, 16'h0012};
    tbl[5] = '{24'h000200, 1'b1, 1'b1, 16'h0000, 16'h1111, 2, 2, 6, 1'b1, 16'h0012};
    tbl[6] = '{24'h000001, 1'b1, 1'b0, 16'h0000, 16'h12AB, 1, -1, 6, 1'b0, 16'h00AB};
    tbl[7] = '{24'h000010, 1'b0, 1'b1, 16'h1234, 16'h0000, 0, -1, 5, 1'b0, 16'h00AB};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", 32'({as_n, uds_n, lds_n, o_rw, doe, busy, done, err}), 32'(8'b1111_0000));
    chk("reset_data", 32'(a) | 32'(dout) | 32'(rdata), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i].ad, tbl[i].r, tbl[i].s, tbl[i].wd, tbl[i].di, tbl[i].d, tbl[i].b, dc, e, rd);
      chk($sformatf("tbl%0d_done_cycle", i), 32'(dc), 32'(tbl[i].ex_cyc));
      chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].ex_err));
      chk($sformatf("tbl%0d_rdata", i), 32'(rd), 32'(tbl[i].ex_rd));
    end
    // a request while DTACK is still low from a previous responder must not start
    @(negedge clk);
    req = 1'b1; dtack_n = 1'b0; addr = 24'h000040; rw = 1'b1; size = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("holdoff_busy", 32'({busy, as_n}), 32'(2'b01));
    req = 1'b0; dtack_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("holdoff_idle", 32'(busy), 32'd0);
    for (int i = 0; i < 40; i++) begin
      d = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 5));
      b = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
      run_txn(24'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), d, b, dc, e, rd);
    end
    // reset pulsed during WAIT aborts the cycle with no completion
    @(negedge clk);
    req = 1'b1; addr = 24'h000100; rw = 1'b1; size = 1'b1; dtack_n = 1'b1; berr_n = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_reset_wait", 32'({as_n, uds_n, lds_n, busy}), 32'(4'b0001));
    rst = 1'b1;
    #1;
    chk("async_reset", 32'({as_n, uds_n, lds_n, busy, done, err}), 32'(6'b111000));
    @(negedge clk);
    rst = 1'b0;
    m_rdata = '0;
    dc = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done) dc++;
    end
    chk("no_done_after_abort", 32'(dc), 32'd0);
    run_txn(24'h000100, 1'b1, 1'b1, 16'h0000, 16'hCAFE, 0, -1, dc, e, rd);
    chk("post_reset_done_cycle", 32'(dc), 32'd5);
    chk("post_reset_rdata", 32'({e, rd}), 32'({1'b0, 16'hCAFE}));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
